axi4lite_rd_arbiter: RTL and testbench

//  Two-master to one-slave AXI4-Lite arbiter placed directly upstream of the SRAM slave.
//  The IFU (read-only) and LSU (read/write) masters share the slave's AR/R channels; this block serialises them.

---
 rtl/axi4lite_pkg.sv | 15 +
 rtl/axi4lite_rd_arbiter_arb2_pick.sv | 27 ++
 rtl/axi4lite_rd_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_axi4lite_rd_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the AXI4-Lite read arbiter.
// Optional feature macro used by this slice: AXI_ARB_RR_EN.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  localparam logic       ID_IFU    = 1'b0;
  localparam logic       ID_LSU    = 1'b1;
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi4lite_rd_arbiter_arb2_pick.sv
// Combinational two-way pick between IFU and LSU read requests.
// AXI_ARB_RR_EN selects round-robin on ties; otherwise LSU wins ties.
module arb2_pick
  import axi4lite_pkg::*;
(
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic last_grant,
  output logic grant_lsu
);

`ifdef AXI_ARB_RR_EN
  always_comb begin
    if (req_ifu && req_lsu) begin
      // Tie goes to whoever did not win the previous grant.
      grant_lsu = (last_grant == ID_IFU);
    end else begin
      grant_lsu = req_lsu;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant ^ req_ifu;
  assign grant_lsu = req_lsu;
`endif

endmodule

// File: rtl/axi4lite_rd_arbiter.sv
// Serialises IFU and LSU reads onto one AXI4-Lite slave; LSU writes pass straight through.
// Define AXI_ARB_RR_EN for round-robin tie breaking instead of fixed LSU-first.
module axi4lite_rd_arbiter
  import axi4lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_arvalid,
  input  logic [ADDR_WIDTH-1:0] ifu_araddr,
  output logic                  ifu_arready,
  output logic                  ifu_rvalid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  input  logic                  ifu_rready,
  input  logic                  lsu_arvalid,
  input  logic [ADDR_WIDTH-1:0] lsu_araddr,
  output logic                  lsu_arready,
  output logic                  lsu_rvalid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  input  logic                  lsu_rready,
  input  logic                  lsu_awvalid,
  input  logic [ADDR_WIDTH-1:0] lsu_awaddr,
  output logic                  lsu_awready,
  input  logic                  lsu_wvalid,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [DATA_WIDTH-1:0] lsu_wstrb,
  output logic                  lsu_wready,
  output logic                  lsu_bvalid,
  output logic [1:0]            lsu_bresp,
  input  logic                  lsu_bready,
  output logic                  s_arvalid,
  output logic                  s_arid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  output logic                  s_rready,
  output logic                  s_awvalid,
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awready,
  output logic                  s_wvalid,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [DATA_WIDTH-1:0] s_wstrb,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  input  logic [1:0]            s_bresp,
  output logic                  s_bready
);

  rd_state_t             state_q, state_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_pending_q, wr_pending_d;
  logic                  last_grant;
  logic                  lsu_elig;
  logic                  grant_lsu;
  logic                  ar_open;
  logic                  ar_hs;
  logic                  r_hs;

  // Read-after-write ordering: LSU reads wait until its writes have responded.
  assign lsu_elig = lsu_arvalid && !wr_pending_q;

  arb2_pick u_pick (
    .req_ifu    (ifu_arvalid),
    .req_lsu    (lsu_elig),
    .last_grant (last_grant),
    .grant_lsu  (grant_lsu)
  );

  // Reset is folded in so arready drops the instant rst falls.
  assign ar_open     = (state_q == RD_IDLE) && rst;
  assign ifu_arready = ar_open && ifu_arvalid && !grant_lsu;
  assign lsu_arready = ar_open && lsu_elig && grant_lsu;
  assign ar_hs       = (ifu_arvalid && ifu_arready) || (lsu_arvalid && lsu_arready);

  assign s_arvalid = (state_q == RD_ADDR);
  assign s_arid    = owner_q;
  assign s_araddr  = addr_q;

  always_comb begin
    s_rready   = 1'b0;
    ifu_rvalid = 1'b0;
    lsu_rvalid = 1'b0;
    ifu_rdata  = '0;
    lsu_rdata  = '0;
    ifu_rresp  = RESP_OKAY;
    lsu_rresp  = RESP_OKAY;
    if (state_q == RD_DATA) begin
      if (owner_q == ID_LSU) begin
        lsu_rvalid = s_rvalid;
        lsu_rdata  = s_rdata;
        lsu_rresp  = s_rresp;
        s_rready   = lsu_rready;
      end else begin
        ifu_rvalid = s_rvalid;
        ifu_rdata  = s_rdata;
        ifu_rresp  = s_rresp;
        s_rready   = ifu_rready;
      end
    end
  end

  assign r_hs = s_rvalid && s_rready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    unique case (state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          state_d = RD_ADDR;
          owner_d = grant_lsu ? ID_LSU : ID_IFU;
          addr_d  = grant_lsu ? lsu_araddr : ifu_araddr;
        end
      end
      RD_ADDR: if (s_arready) state_d = RD_DATA;
      RD_DATA: if (r_hs) state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  // A new write wins over a same-cycle response so the newer write stays tracked.
  always_comb begin
    wr_pending_d = wr_pending_q;
    if (lsu_awvalid && s_awready) begin
      wr_pending_d = 1'b1;
    end else if (s_bvalid && lsu_bready) begin
      wr_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RD_IDLE;
      owner_q      <= ID_IFU;
      addr_q       <= '0;
      wr_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wr_pending_q <= wr_pending_d;
    end
  end

`ifdef AXI_ARB_RR_EN
  logic last_grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= ID_LSU;
    end else if (ar_hs) begin
      last_grant_q <= grant_lsu ? ID_LSU : ID_IFU;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = ID_LSU;
`endif

  assign s_awvalid   = lsu_awvalid;
  assign s_awaddr    = lsu_awaddr;
  assign lsu_awready = s_awready;
  assign s_wvalid    = lsu_wvalid;
  assign s_wdata     = lsu_wdata;
  assign s_wstrb     = lsu_wstrb;
  assign lsu_wready  = s_wready;
  assign lsu_bvalid  = s_bvalid;
  assign lsu_bresp   = s_bresp;
  assign s_bready    = lsu_bready;

endmodule

// File: tb/tb_axi4lite_rd_arbiter.sv
// Self-checking bench for axi4lite_rd_arbiter: directed steps plus randomized rounds
// checked against a request-level model of eligibility, priority and routing.
module tb_axi4lite_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [31:0] lsu_awaddr, lsu_wdata, lsu_wstrb;
  logic [1:0]  lsu_bresp;
  logic        s_arvalid, s_arid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [1:0]  s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata, s_wstrb;
  logic [1:0]  s_bresp;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: pending write and the master that won the last AR handshake.
  bit m_pend;
  bit m_last;
  bit grants[$];

  axi4lite_rd_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp),
    .lsu_bready(lsu_bready),
    .s_arvalid(s_arvalid), .s_arid(s_arid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // 1 = LSU wins, 0 = IFU wins.
  function automatic bit pick(input bit e_i, input bit e_l);
    if (e_i && e_l) begin
`ifdef AXI_ARB_RR_EN
      return !m_last;
`else
      return 1'b1;
`endif
    end
    return e_l;
  endfunction

  // One read round; called and returns at posedge+1.
  task automatic round(input bit rq_i, input bit rq_l, input logic [31:0] a_i,
                       input logic [31:0] a_l, input logic [31:0] d,
                       input int stall, input int hold);
    bit w;
    logic [31:0] wa;
    logic [1:0]  rr;
    ifu_arvalid = rq_i; ifu_araddr = a_i;
    lsu_arvalid = rq_l; lsu_araddr = a_l;
    @(negedge clk);
    if (!rq_i && !(rq_l && !m_pend)) begin
      chk("blocked_ifu_arready", ifu_arready, 0);
      chk("blocked_lsu_arready", lsu_arready, 0);
      @(posedge clk); #1;
      ifu_arvalid = 0; lsu_arvalid = 0;
      return;
    end
    w  = pick(rq_i, rq_l && !m_pend);
    wa = w ? a_l : a_i;
    chk("grant_ifu_arready", ifu_arready, !w);
    chk("grant_lsu_arready", lsu_arready, w);
    chk("idle_s_arvalid", s_arvalid, 0);
    @(posedge clk); #1;
    m_last = w;
    grants.push_back(w);
    // Winner drops arvalid and scribbles its address: the latched copy must hold.
    if (w) begin lsu_arvalid = 0; lsu_araddr = $urandom; end
    else begin ifu_arvalid = 0; ifu_araddr = $urandom; end
    s_arready = 0;
    repeat (stall) begin
      @(negedge clk);
      chk("stall_s_arvalid", s_arvalid, 1);
      chk("stall_s_araddr", s_araddr, wa);
      chk("stall_arready", {ifu_arready, lsu_arready}, 0);
      @(posedge clk); #1;
    end
    s_arready = 1;
    @(negedge clk);
    chk("addr_s_arvalid", s_arvalid, 1);
    chk("addr_s_arid", s_arid, w);
    chk("addr_s_araddr", s_araddr, wa);
    @(posedge clk); #1;
    s_arready = 0;
    s_rvalid = 1; s_rdata = d; rr = 2'($urandom); s_rresp = rr;
    if (w) ifu_rready = 1; else lsu_rready = 1;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_owner_rvalid", w ? lsu_rvalid : ifu_rvalid, 1);
      chk("hold_other_rvalid", w ? ifu_rvalid : lsu_rvalid, 0);
      chk("hold_s_rready", s_rready, 0);
      chk("hold_arready", {ifu_arready, lsu_arready}, 0);
      @(posedge clk); #1;
    end
    if (w) begin lsu_rready = 1; ifu_rready = 0; end
    else begin ifu_rready = 1; lsu_rready = 0; end
    @(negedge clk);
    chk("data_owner_rvalid", w ? lsu_rvalid : ifu_rvalid, 1);
    chk("data_owner_rdata", w ? lsu_rdata : ifu_rdata, d);
    chk("data_owner_rresp", w ? lsu_rresp : ifu_rresp, rr);
    chk("data_other_rvalid", w ? ifu_rvalid : lsu_rvalid, 0);
    chk("data_s_rready", s_rready, 1);
    chk("data_s_arvalid", s_arvalid, 0);
    @(posedge clk); #1;
    s_rvalid = 0; ifu_rready = 0; lsu_rready = 0;
  endtask

  task automatic wr_step(input bit do_aw, input bit do_b, input logic [31:0] a,
                         input logic [31:0] strb);
    logic [31:0] wd;
    logic [1:0]  br;
    wd = $urandom; br = 2'($urandom);
    lsu_awvalid = do_aw; lsu_awaddr = a; lsu_wvalid = do_aw; lsu_wdata = wd;
    lsu_wstrb = strb; s_awready = do_aw; s_wready = do_aw;
    s_bvalid = do_b; s_bresp = br; lsu_bready = do_b;
    @(negedge clk);
    if (do_aw) begin
      chk("wr_s_awvalid", s_awvalid, 1);
      chk("wr_s_awaddr", s_awaddr, a);
      chk("wr_s_wdata", s_wdata, wd);
      chk("wr_s_wstrb", s_wstrb, strb);
      chk("wr_lsu_ready", {lsu_awready, lsu_wready}, 2'b11);
    end
    if (do_b) begin
      chk("wr_lsu_bvalid", lsu_bvalid, 1);
      chk("wr_lsu_bresp", lsu_bresp, br);
      chk("wr_s_bready", s_bready, 1);
    end
    @(posedge clk); #1;
    if (do_aw) m_pend = 1;
    else if (do_b) m_pend = 0;
    lsu_awvalid = 0; lsu_wvalid = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 0; lsu_bready = 0;
  endtask

  initial begin
    bit ri, rl;
    rst = 0;
    ifu_arvalid = 1; lsu_arvalid = 1; ifu_araddr = 0; lsu_araddr = 0;
    ifu_rready = 0; lsu_rready = 0;
    lsu_awvalid = 0; lsu_awaddr = 0; lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0;
    lsu_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    m_pend = 0; m_last = 1;

    // Reset state with requests already pending.
    #3;
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_arready", {ifu_arready, lsu_arready}, 0);
    chk("rst_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
    ifu_arvalid = 0; lsu_arvalid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;

    // IFU fetch routed back to IFU only.
    round(1, 0, 32'h8000_0000, 0, 32'h0000_0413, 0, 0);
    // Tie, then IFU (still waiting) gets the very next cycle.
    round(1, 1, 32'h8000_0040, 32'h8000_2000, 32'hCAFE_0001, 1, 0);
    round(1, 0, 32'h8000_0040, 0, 32'hCAFE_0002, 0, 0);
    // Three back-to-back ties.
    round(1, 1, 32'h8000_0100, 32'h8000_3000, 32'h1111_0000, 0, 0);
    round(1, 1, 32'h8000_0104, 32'h8000_3004, 32'h2222_0000, 0, 0);
    round(1, 1, 32'h8000_0108, 32'h8000_3008, 32'h3333_0000, 0, 0);
    // Owner holds rready low for 3 cycles.
    round(0, 1, 0, 32'h8000_4000, 32'hDEAD_BEEF, 2, 3);

    // Write blocks LSU reads until its response; IFU proceeds meanwhile.
    wr_step(1, 0, 32'h8000_1000, 32'h3);
    round(0, 1, 0, 32'h8000_1000, 32'h0, 0, 0);
    round(1, 1, 32'h8000_0200, 32'h8000_1000, 32'h5555_AAAA, 0, 1);
    round(0, 1, 0, 32'h8000_1000, 32'h0, 0, 0);
    wr_step(1, 1, 32'h8000_1004, 32'hF);
    round(0, 1, 0, 32'h8000_1004, 32'h0, 0, 0);
    wr_step(0, 1, 0, 0);
    round(0, 1, 0, 32'h8000_1004, 32'h7777_0001, 0, 0);

    // Asynchronous reset while in RD_ADDR drops the read.
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0300;
    @(posedge clk); #1;
    ifu_arvalid = 0;
    @(negedge clk);
    chk("pre_rst_s_arvalid", s_arvalid, 1);
    @(posedge clk); #2;
    rst = 0;
    ifu_arvalid = 1;
    #1;
    chk("midrst_s_arvalid", s_arvalid, 0);
    chk("midrst_arready", {ifu_arready, lsu_arready}, 0);
    @(posedge clk); #1;
    rst = 1; m_pend = 0; m_last = 1;
    round(1, 0, 32'h8000_0304, 0, 32'h0BAD_F00D, 0, 0);

    // Randomized mix of reads and writes.
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0 && !m_pend) wr_step(1, 0, $urandom, $urandom);
      else if (r == 1 && m_pend) wr_step(0, 1, 0, 0);
      else begin
        ri = 1'($urandom); rl = 1'($urandom);
        if (!ri && !rl) ri = 1;
        round(ri, rl, $urandom, $urandom, $urandom,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
